// File: rtl/fpu_pkg.sv
// Shared types and constants for the FPU configuration-stream transmitter.
// The beat_word helper defines the order in which the eight words go out.
package fpu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_DONE
  } fpu_state_e;

  localparam logic [31:0] FPU_CMD_START = 32'h0000_0001;
  localparam int          FPU_CFG_BEATS = 8;

  localparam logic [2:0] CFG_CTRL     = 3'd0;
  localparam logic [2:0] CFG_FILT0    = 3'd1;
  localparam logic [2:0] CFG_FILT1    = 3'd2;
  localparam logic [2:0] CFG_FILT2    = 3'd3;
  localparam logic [2:0] CFG_WIDTH    = 3'd4;
  localparam logic [2:0] CFG_HEIGHT   = 3'd5;
  localparam logic [2:0] CFG_SRC_ADDR = 3'd6;
  localparam logic [2:0] CFG_DST_ADDR = 3'd7;

  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_CLEAR_BIT = 1;

  typedef logic [2:0] beat_idx_t;

  localparam beat_idx_t LAST_BEAT = beat_idx_t'(FPU_CFG_BEATS - 1);

  // CPU-visible shadow set; CTRL is a strobe register and is not stored.
  typedef struct packed {
    logic [31:0] filt0;
    logic [31:0] filt1;
    logic [31:0] filt2;
    logic [31:0] width;
    logic [31:0] height;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
  } cfg_regs_t;

  typedef struct packed {
    logic done;
    logic err_busy;
    logic err_param;
    logic err_timeout;
  } sticky_t;

  function automatic logic [31:0] beat_word(input cfg_regs_t regs, input beat_idx_t idx);
    logic [31:0] word;
    case (idx)
      3'd1:    word = regs.filt0;
      3'd2:    word = regs.filt1;
      3'd3:    word = regs.filt2;
      3'd4:    word = regs.width;
      3'd5:    word = regs.height;
      3'd6:    word = regs.src_addr;
      3'd7:    word = regs.dst_addr;
      default: word = FPU_CMD_START;
    endcase
    return word;
  endfunction

endpackage

// File: rtl/fpu_watchdog.sv
// Clear/enable up-counter that flags when it sits on its last count.
// The counter saturates there, so a late enable never wraps back to zero.
module fpu_watchdog #(
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_q, count_d;

  // NOTE: every combinational output gets its default first, so no branch can infer a latch.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != LAST_COUNT)) begin
      count_d = count_q + CW'(1);
    end
  end

  // NOTE: state is updated with <= only; blocking writes here would race other flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = en_i && (count_q == LAST_COUNT);

endmodule

// File: rtl/fpu_cfg_sender.sv
// Host-side transmitter of the FPU configuration stream: CPU shadow registers,
// an 8-beat launch sequence with stall backpressure, and a done/watchdog wait.
module fpu_cfg_sender
  import fpu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1048576,
  parameter int MIN_DIM        = 3,
  parameter int MAX_DIM        = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_wr,
  input  logic [2:0]  cfg_addr,
  input  logic [31:0] cfg_wdata,
  input  logic        stall,
  input  logic        fpu_done,
  output logic [31:0] data_mem,
  output logic        mapped_data_valid,
  output logic        busy,
  output logic        done,
  output logic        err_busy,
  output logic        err_param,
  output logic        err_timeout
);

  localparam logic [31:0] MIN_DIM_W = 32'(MIN_DIM);
  localparam logic [31:0] MAX_DIM_W = 32'(MAX_DIM);

  fpu_state_e state_q, state_d;
  beat_idx_t  idx_q, idx_d;
  cfg_regs_t  regs_q, regs_d;
  sticky_t    sticky_q, sticky_d;

  logic in_job;
  logic ctrl_wr;
  logic clear_only;
  logic clear_req;
  logic start_req;
  logic dims_ok;
  logic wd_expired;

  function automatic logic dim_legal(input logic [31:0] dim);
    return (dim >= MIN_DIM_W) && (dim <= MAX_DIM_W);
  endfunction

  assign in_job     = (state_q != IDLE);
  assign ctrl_wr    = cfg_wr && (cfg_addr == CFG_CTRL);
  assign clear_only = ctrl_wr && cfg_wdata[CTRL_CLEAR_BIT] && !cfg_wdata[CTRL_START_BIT];
  // During a job only the clear-only CTRL write gets through; everything else is refused.
  assign clear_req  = in_job ? clear_only : (ctrl_wr && cfg_wdata[CTRL_CLEAR_BIT]);
  assign start_req  = !in_job && ctrl_wr && cfg_wdata[CTRL_START_BIT];
  assign dims_ok    = dim_legal(regs_q.width) && dim_legal(regs_q.height);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    regs_d   = regs_q;
    // Clear is applied before any set below, so a same-cycle event survives it.
    sticky_d = clear_req ? '0 : sticky_q;

    if (in_job && cfg_wr && !clear_only) begin
      sticky_d.err_busy = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (cfg_wr) begin
          case (cfg_addr)
            CFG_FILT0:    regs_d.filt0    = cfg_wdata;
            CFG_FILT1:    regs_d.filt1    = cfg_wdata;
            CFG_FILT2:    regs_d.filt2    = cfg_wdata;
            CFG_WIDTH:    regs_d.width    = cfg_wdata;
            CFG_HEIGHT:   regs_d.height   = cfg_wdata;
            CFG_SRC_ADDR: regs_d.src_addr = cfg_wdata;
            CFG_DST_ADDR: regs_d.dst_addr = cfg_wdata;
            default:      ;
          endcase
        end
        if (start_req) begin
          if (dims_ok) begin
            state_d = SEND;
            idx_d   = '0;
          end else begin
            sticky_d.err_param = 1'b1;
          end
        end
      end

      SEND: begin
        if (!stall) begin
          idx_d = idx_q + beat_idx_t'(1);
          if (idx_q == LAST_BEAT) begin
            state_d = WAIT_DONE;
          end
        end
      end

      WAIT_DONE: begin
        // A done pulse on the expiry cycle takes priority over the timeout.
        if (fpu_done) begin
          state_d       = IDLE;
          sticky_d.done = 1'b1;
        end else if (wd_expired) begin
          state_d              = IDLE;
          sticky_d.err_timeout = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      // NOTE: the shadow set is reset too; software may launch without writing every register.
      regs_q   <= '0;
      sticky_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      regs_q   <= regs_d;
      sticky_q <= sticky_d;
    end
  end

  fpu_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (state_q != WAIT_DONE),
    .en_i     (state_q == WAIT_DONE),
    .expired_o(wd_expired)
  );

  // Valid is decoded straight from the state flop so an async reset drops it at once.
  assign mapped_data_valid = (state_q == SEND);
  assign data_mem          = mapped_data_valid ? beat_word(regs_q, idx_q) : '0;
  assign busy              = in_job;
  assign done              = sticky_q.done;
  assign err_busy          = sticky_q.err_busy;
  assign err_param         = sticky_q.err_param;
  assign err_timeout       = sticky_q.err_timeout;

endmodule

// File: tb/tb_fpu_cfg_sender.sv
// Self-checking bench for fpu_cfg_sender: directed scenarios, a dimension table,
// and randomized jobs checked against a register-level model of the host interface.
module tb_fpu_cfg_sender;

  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cfg_wr = 1'b0;
  logic [2:0]  cfg_addr = '0;
  logic [31:0] cfg_wdata = '0;
  logic        stall = 1'b0;
  logic        fpu_done = 1'b0;
  logic [31:0] data_mem;
  logic        mapped_data_valid;
  logic        busy;
  logic        done;
  logic        err_busy;
  logic        err_param;
  logic        err_timeout;

  int errors = 0;
  int checks = 0;

  // Model: register contents plus job/flag status, updated per accepted host action.
  logic [31:0] m_reg [0:7];
  bit m_busy, m_done, m_eb, m_ep, m_et;

  typedef struct {
    logic [31:0] w;
    logic [31:0] h;
    bit          reject;
  } vec_t;

  vec_t vecs [8];

  fpu_cfg_sender #(
    .TIMEOUT_CYCLES(TIMEOUT),
    .MIN_DIM       (3),
    .MAX_DIM       (4096)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .cfg_wr           (cfg_wr),
    .cfg_addr         (cfg_addr),
    .cfg_wdata        (cfg_wdata),
    .stall            (stall),
    .fpu_done         (fpu_done),
    .data_mem         (data_mem),
    .mapped_data_valid(mapped_data_valid),
    .busy             (busy),
    .done             (done),
    .err_busy         (err_busy),
    .err_param        (err_param),
    .err_timeout      (err_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic bit dim_ok(input logic [31:0] d);
    return (d >= 32'd3) && (d <= 32'd4096);
  endfunction

  function automatic void model_clear();
    m_done = 0; m_eb = 0; m_ep = 0; m_et = 0;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) m_reg[i] = '0;
    m_busy = 0;
    model_clear();
  endfunction

  function automatic void model_write(input logic [2:0] a, input logic [31:0] d);
    if (m_busy) begin
      if (a == 3'd0 && d[1:0] == 2'b10) model_clear();
      else m_eb = 1;
    end else if (a == 3'd0) begin
      if (d[1]) model_clear();
      if (d[0]) begin
        if (dim_ok(m_reg[4]) && dim_ok(m_reg[5])) m_busy = 1;
        else m_ep = 1;
      end
    end else begin
      m_reg[a] = d;
    end
  endfunction

  task automatic check_flags(input string tag);
    check({tag, ".busy"}, busy, m_busy);
    check({tag, ".done"}, done, m_done);
    check({tag, ".err_busy"}, err_busy, m_eb);
    check({tag, ".err_param"}, err_param, m_ep);
    check({tag, ".err_timeout"}, err_timeout, m_et);
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [31:0] d);
    cfg_addr  = a;
    cfg_wdata = d;
    cfg_wr    = 1'b1;
    model_write(a, d);
    @(posedge clk); #1;
    cfg_wr = 1'b0;
  endtask

  // Streams one job: every cycle valid must be high and data must be the next
  // unconsumed word; a word is consumed only on cycles driven with stall=0.
  task automatic send_job(input string tag, input logic [63:0] smask, input int inj_cyc,
                          input logic [2:0] inj_a, input logic [31:0] inj_d);
    logic [31:0] exp_q [$];
    int k = 0;
    int cyc = 0;
    exp_q.push_back(32'h0000_0001);
    for (int i = 1; i < 8; i++) exp_q.push_back(m_reg[i]);
    while (k < 8 && cyc < 100) begin
      check({tag, ".valid"}, mapped_data_valid, 1);
      check($sformatf("%s.beat%0d", tag, k), data_mem, exp_q[k]);
      stall = (cyc < 64) ? smask[cyc] : 1'b0;
      if (cyc == inj_cyc) begin
        cfg_addr  = inj_a;
        cfg_wdata = inj_d;
        cfg_wr    = 1'b1;
        model_write(inj_a, inj_d);
      end
      @(posedge clk); #1;
      cfg_wr = 1'b0;
      if (!stall) k++;
      cyc++;
    end
    stall = 1'b0;
    check({tag, ".valid_drop"}, mapped_data_valid, 0);
    check_flags({tag, ".sent"});
  endtask

  // Waits in WAIT_DONE; done_at is the cycle index after entry at which fpu_done
  // pulses (out of range means never). Cycle TIMEOUT-1 is the last one allowed.
  task automatic wait_phase(input string tag, input int done_at);
    for (int c = 0; c < TIMEOUT; c++) begin
      check({tag, ".busy_wait"}, busy, 1);
      fpu_done = (c == done_at);
      @(posedge clk); #1;
      fpu_done = 1'b0;
      if (c == done_at) begin
        m_done = 1; m_busy = 0;
        break;
      end
      if (c == TIMEOUT - 1) begin
        m_et = 1; m_busy = 0;
      end
    end
    check_flags({tag, ".end"});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: bench still running at %0t", $time);
    $fatal(1, "bench time limit");
  end

  initial begin
    logic [31:0] v;
    logic [63:0] smask;
    int inj;

    vecs[0] = '{32'd2,    32'd8,    1'b1};
    vecs[1] = '{32'd3,    32'd8,    1'b0};
    vecs[2] = '{32'd4096, 32'd3,    1'b0};
    vecs[3] = '{32'd4097, 32'd16,   1'b1};
    vecs[4] = '{32'd16,   32'd2,    1'b1};
    vecs[5] = '{32'd16,   32'd4097, 1'b1};
    vecs[6] = '{32'd0,    32'd0,    1'b1};
    vecs[7] = '{32'd3,    32'd4096, 1'b0};

    model_reset();
    #1 rst_n = 1'b0;
    #1;
    check("reset.valid", mapped_data_valid, 0);
    check("reset.data", data_mem, 0);
    check_flags("reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // T1 nominal job
    cfg_write(3'd1, 32'h0403_0201);
    cfg_write(3'd2, 32'h0807_0605);
    cfg_write(3'd3, 32'h0000_0009);
    cfg_write(3'd4, 32'd16);
    cfg_write(3'd5, 32'd8);
    cfg_write(3'd6, 32'h1000);
    cfg_write(3'd7, 32'h2000);
    check("t1.idle_valid", mapped_data_valid, 0);
    cfg_write(3'd0, 32'h1);
    check("t1.first_beat", data_mem, 32'h0000_0001);
    send_job("t1", 64'h0, -1, 3'd0, 32'h0);
    wait_phase("t1", 20);

    // T2 stall held on beat 4 (WIDTH) for five cycles
    cfg_write(3'd0, 32'h3);
    send_job("t2", 64'h1F0, -1, 3'd0, 32'h0);
    wait_phase("t2", 3);

    // T3 dimension bounds and stray fpu_done in IDLE
    for (int i = 0; i < 8; i++) begin
      cfg_write(3'd4, vecs[i].w);
      cfg_write(3'd5, vecs[i].h);
      cfg_write(3'd0, 32'h3);
      check($sformatf("vec%0d.err_param", i), err_param, vecs[i].reject);
      check($sformatf("vec%0d.busy", i), busy, !vecs[i].reject);
      check_flags($sformatf("vec%0d", i));
      if (vecs[i].reject) begin
        fpu_done = 1'b1;
        @(posedge clk); #1;
        fpu_done = 1'b0;
        check($sformatf("vec%0d.no_valid", i), mapped_data_valid, 0);
        check($sformatf("vec%0d.stray_done", i), done, 0);
      end else begin
        send_job($sformatf("vec%0d", i), 64'h0, -1, 3'd0, 32'h0);
        wait_phase($sformatf("vec%0d", i), 5);
      end
    end

    // T4 refused SRC write while busy, then clear-only write honoured mid-job
    cfg_write(3'd4, 32'd16);
    cfg_write(3'd5, 32'd8);
    cfg_write(3'd6, 32'h1000);
    cfg_write(3'd0, 32'h3);
    send_job("t4", 64'h0, 2, 3'd6, 32'hDEAD_BEEF);
    check("t4.err_busy", err_busy, 1);
    wait_phase("t4", 2);
    cfg_write(3'd0, 32'h1);
    check_flags("t4b.start");
    send_job("t4b", 64'h0, 4, 3'd0, 32'h2);
    check("t4b.err_busy_cleared", err_busy, 0);
    wait_phase("t4b", 1);

    // T5 watchdog expiry, then fpu_done on the expiry cycle
    cfg_write(3'd0, 32'h3);
    send_job("t5", 64'h0, -1, 3'd0, 32'h0);
    wait_phase("t5", -1);
    check("t5.err_timeout", err_timeout, 1);
    cfg_write(3'd0, 32'h3);
    send_job("t5b", 64'h0, -1, 3'd0, 32'h0);
    wait_phase("t5b", TIMEOUT - 1);
    check("t5b.err_timeout", err_timeout, 0);

    // T6 asynchronous reset during beat 3
    cfg_write(3'd0, 32'h3);
    repeat (3) @(posedge clk);
    #1;
    check("t6.beat3", data_mem, m_reg[3]);
    #2 rst_n = 1'b0;
    #1;
    check("t6.valid_async", mapped_data_valid, 0);
    check("t6.data_async", data_mem, 0);
    model_reset();
    check_flags("t6.reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    cfg_write(3'd0, 32'h1);
    check_flags("t6.zero_dims");
    cfg_write(3'd4, 32'd5);
    cfg_write(3'd5, 32'd7);
    cfg_write(3'd0, 32'h3);
    send_job("t6", 64'h0, -1, 3'd0, 32'h0);
    wait_phase("t6", 4);

    // Randomized jobs
    for (int it = 0; it < 25; it++) begin
      for (int a = 1; a < 8; a++) begin
        v = $urandom;
        if (a == 4 || a == 5) begin
          v = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 2) : $urandom_range(3, 4096);
        end
        if ($urandom_range(0, 1) == 1) cfg_write(a[2:0], v);
      end
      cfg_write(3'd0, ($urandom_range(0, 1) == 1) ? 32'h3 : 32'h1);
      check_flags("rnd.start");
      if (m_busy) begin
        smask = {$urandom, $urandom} & {$urandom, $urandom};
        inj = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 7)) : -1;
        send_job("rnd", smask, inj, 3'($urandom_range(0, 7)),
                 ($urandom_range(0, 3) == 0) ? 32'h2 : $urandom);
        wait_phase("rnd", ($urandom_range(0, 5) == 0) ? TIMEOUT + 5 : int'($urandom_range(0, 40)));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
